// File: rtl/scan_tester.sv
`default_nettype none
// ============================================================================
// Module   : scan_tester
// Brief    : Shifts a stimulus into a scan chain, pulses one capture cycle,
//            shifts the response out and scores it against a masked expectation.
// Revision : 1.0 - initial release
// ============================================================================
module scan_tester #(
    parameter int CHAIN_LEN = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] mask,
    output logic                 mode,
    output logic                 SDI,
    input  logic                 SDO,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] resp,
    output logic                 pass,
    output logic [CNT_W-1:0]     test_cnt,
    output logic [CNT_W-1:0]     fail_cnt
);

    localparam int                c_CW   = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_CAPTURE   = 3'd2,
        S_SHIFT_OUT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic                   w_latch;
    logic [CHAIN_LEN-1:0]   r_pattern;
    logic [CHAIN_LEN-1:0]   r_expected;
    logic [CHAIN_LEN-1:0]   r_mask;
    logic [CHAIN_LEN-1:0]   w_pat_src;
    logic                   w_sdi_nxt;
    logic [CHAIN_LEN-1:0]   w_resp_nxt;
    logic                   w_pass_nxt;
    logic                   r_mode;
    logic                   r_sdi;
    logic                   r_busy;
    logic                   r_done;
    logic [CHAIN_LEN-1:0]   r_resp;
    logic                   r_pass;
    logic [CNT_W-1:0]       r_test_cnt;
    logic [CNT_W-1:0]       r_fail_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_SHIFT_IN;
                end
            end
            S_SHIFT_IN: begin
                if (r_cnt == c_LAST) w_state_nxt = S_CAPTURE;
                else                 w_cnt_nxt   = r_cnt + c_CW'(1);
            end
            S_CAPTURE:  w_state_nxt = S_SHIFT_OUT;
            S_SHIFT_OUT: begin
                if (r_cnt == c_LAST) w_state_nxt = S_DONE;
                else                 w_cnt_nxt   = r_cnt + c_CW'(1);
            end
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so the first shift bit must
    // come straight from the input pattern on the accepting edge.
    always_comb begin
        w_pat_src  = w_latch ? pattern : r_pattern;
        w_sdi_nxt  = (w_state_nxt == S_SHIFT_IN) ? w_pat_src[w_cnt_nxt] : 1'b0;
        w_resp_nxt = r_resp;
        w_resp_nxt[r_cnt] = SDO;
        w_pass_nxt = ((w_resp_nxt ^ r_expected) & r_mask) == '0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pattern  <= '0;
            r_expected <= '0;
            r_mask     <= '0;
            r_mode     <= 1'b0;
            r_sdi      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_resp     <= '0;
            r_pass     <= 1'b0;
            r_test_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_pattern  <= pattern;
                r_expected <= expected;
                r_mask     <= mask;
            end
            r_mode <= (w_state_nxt == S_SHIFT_IN) || (w_state_nxt == S_SHIFT_OUT);
            r_sdi  <= w_sdi_nxt;
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            if (r_state == S_SHIFT_OUT) r_resp <= w_resp_nxt;
            // Score on the edge that samples the last response bit.
            if (r_state == S_SHIFT_OUT && w_state_nxt == S_DONE) begin
                r_pass <= w_pass_nxt;
                if (r_test_cnt != '1) r_test_cnt <= r_test_cnt + CNT_W'(1);
                if (!w_pass_nxt && r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            end
        end
    end

    assign mode     = r_mode;
    assign SDI      = r_sdi;
    assign busy     = r_busy;
    assign done     = r_done;
    assign resp     = r_resp;
    assign pass     = r_pass;
    assign test_cnt = r_test_cnt;
    assign fail_cnt = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scan_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_tester
// Brief    : Directed bench for scan_tester driving a 2-flop rotating scan chain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_tester;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start, start2;
    logic [1:0] pattern, expected, mask;
    logic       mode, sdi, busy, done, pass;
    logic [1:0] resp;
    logic [7:0] test_cnt, fail_cnt;
    logic       mode2, sdi2, busy2, done2, pass2;
    logic [1:0] resp2, tcnt2, fcnt2;
    logic [1:0] q  = 2'b00;
    logic [1:0] q2 = 2'b00;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: flop 0 drives SDO, SDI enters flop 1; functional step swaps the flops.
    always @(posedge clk) q  <= mode  ? {sdi,  q[1]}  : {q[0],  q[1]};
    always @(posedge clk) q2 <= mode2 ? {sdi2, q2[1]} : {q2[0], q2[1]};

    scan_tester #(.CHAIN_LEN(2), .CNT_W(8)) u_dut (
        .clk(clk), .n_rst(n_rst), .start(start), .pattern(pattern),
        .expected(expected), .mask(mask), .mode(mode), .SDI(sdi), .SDO(q[0]),
        .busy(busy), .done(done), .resp(resp), .pass(pass),
        .test_cnt(test_cnt), .fail_cnt(fail_cnt)
    );

    scan_tester #(.CHAIN_LEN(2), .CNT_W(2)) u_dut_sat (
        .clk(clk), .n_rst(n_rst), .start(start2), .pattern(pattern),
        .expected(expected), .mask(mask), .mode(mode2), .SDI(sdi2), .SDO(q2[0]),
        .busy(busy2), .done(done2), .resp(resp2), .pass(pass2),
        .test_cnt(tcnt2), .fail_cnt(fcnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_test(input logic [1:0] p, input logic [1:0] e, input logic [1:0] m,
                            output logic [1:0] r, output logic ps);
        int  n;
        bit  seen;
        @(negedge clk);
        pattern = p; expected = e; mask = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r = 2'bxx; ps = 1'bx; seen = 1'b0; n = 0;
        while (!seen && n < 20) begin
            if (done) begin
                seen = 1'b1; r = resp; ps = pass;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    logic [1:0] r;
    logic       ps;
    int         ndone;
    int         stamps[3];
    bit         tmode[6];
    bit         tdone[6];

    initial begin
        tmode = '{1, 1, 0, 1, 1, 0};
        tdone = '{0, 0, 0, 0, 0, 1};
        n_rst = 1'b0; start = 1'b0; start2 = 1'b0;
        pattern = 2'b00; expected = 2'b00; mask = 2'b00;
        #1;
        check("rst_mode", mode, 0);
        check("rst_sdi", sdi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resp", resp, 0);
        check("rst_pass", pass, 0);
        check("rst_cnts", {test_cnt, fail_cnt}, 0);
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Basic test, cycle-by-cycle: pattern 01 -> chain 01 -> swap -> 10
        pattern = 2'b01; expected = 2'b10; mask = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("basic_mode_c%0d", i + 1), mode, tmode[i]);
            check($sformatf("basic_done_c%0d", i + 1), done, tdone[i]);
            if (i == 0) check("basic_sdi_c1", sdi, 1);
            if (i == 1) check("basic_sdi_c2", sdi, 0);
            if (i == 0) check("basic_busy_c1", busy, 1);
            if (i == 5) begin
                check("basic_resp", resp, 2'b10);
                check("basic_pass", pass, 1);
                check("basic_busy_done", busy, 1);
            end
            @(negedge clk);
        end
        check("basic_done_low", done, 0);
        check("basic_busy_low", busy, 0);
        check("basic_test_cnt", test_cnt, 1);
        check("basic_fail_cnt", fail_cnt, 0);

        // Reset in the middle of SHIFT_IN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("midrst_mode", mode, 0);
        check("midrst_busy", busy, 0);
        check("midrst_test_cnt", test_cnt, 0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_idle_busy", busy, 0);
            check("midrst_idle_mode", mode, 0);
        end

        // Mismatch and masking: pattern 10 -> response 01, pattern 00 -> response 00
        run_test(2'b10, 2'b10, 2'b11, r, ps);
        check("mis_resp", r, 2'b01);
        check("mis_pass", ps, 0);
        check("mis_fail_cnt", fail_cnt, 1);
        run_test(2'b10, 2'b10, 2'b00, r, ps);
        check("mask0_pass", ps, 1);
        check("mask0_fail_cnt", fail_cnt, 1);
        run_test(2'b00, 2'b01, 2'b10, r, ps);
        check("maskhi_pass", ps, 1);
        run_test(2'b00, 2'b01, 2'b01, r, ps);
        check("masklo_pass", ps, 0);
        check("mask_test_cnt", test_cnt, 4);
        check("mask_fail_cnt", fail_cnt, 2);

        // Start pulsed during SHIFT_OUT, inputs changed while busy
        @(negedge clk);
        pattern = 2'b01; expected = 2'b10; mask = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0; pattern = 2'b10; expected = 2'b00;
        @(negedge clk); @(negedge clk); @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                ndone++;
                check("busy_start_resp", resp, 2'b10);
                check("busy_start_pass", pass, 1);
            end
            @(negedge clk);
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_test_cnt", test_cnt, 5);

        // start held: three back-to-back tests
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        pattern = 2'b01; expected = 2'b10; mask = 2'b11; start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40 && ndone < 3; i++) begin
            @(negedge clk);
            if (done) begin
                stamps[ndone] = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        check("held_ndone", ndone, 3);
        if (ndone == 3) begin
            check("held_gap1", stamps[1] - stamps[0], 7);
            check("held_gap2", stamps[2] - stamps[1], 7);
        end
        @(negedge clk);
        check("held_test_cnt", test_cnt, 3);
        check("held_fail_cnt", fail_cnt, 0);

        // Saturation on the 2-bit counter instance: five failing tests
        pattern = 2'b01; expected = 2'b01; mask = 2'b11; start2 = 1'b1;
        ndone = 0;
        for (int i = 0; i < 60 && ndone < 5; i++) begin
            @(negedge clk);
            if (done2) begin
                ndone++;
                check("sat_pass", pass2, 0);
            end
        end
        start2 = 1'b0;
        check("sat_ndone", ndone, 5);
        @(negedge clk);
        check("sat_test_cnt", tcnt2, 2'b11);
        check("sat_fail_cnt", fcnt2, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
